// File: rtl/conv2d_sequencer.sv
`default_nettype none
// =====================================================================
// Module   : conv2d_sequencer
// Brief    : Strobe/address sequencer for a KxK strided conv2d datapath.
//            Optional cycle counter enabled by CONV2D_SEQUENCER_PERF_EN.
// Revision : 1.0
// =====================================================================
module conv2d_sequencer #(
   parameter int IN_CHANNELS  = 2,
   parameter int OUT_CHANNELS = 1,
   parameter int IN_HEIGHT    = 4,
   parameter int IN_WIDTH     = 4,
   parameter int KERNEL_SIZE  = 2,
   parameter int STRIDE       = 2,
   parameter int PADDING      = 0,
   parameter int ADDR_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  hold,
   output logic                  busy,
   output logic                  done,
   output logic                  acc_init,
   output logic                  mac_en,
   output logic                  in_valid,
   output logic [ADDR_WIDTH-1:0] in_addr,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH-1:0] bias_addr,
   output logic                  out_we,
   output logic [ADDR_WIDTH-1:0] out_addr
`ifdef CONV2D_SEQUENCER_PERF_EN
   ,
   output logic [31:0]           perf_cycles
`endif
);

   localparam int OUT_HEIGHT = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE)/STRIDE + 1;
   localparam int OUT_WIDTH  = (IN_WIDTH  + 2*PADDING - KERNEL_SIZE)/STRIDE + 1;
   localparam int TAPS       = IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE;

   localparam int              c_CW      = 16;
   localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);
   localparam logic [c_CW-1:0] c_K_LAST  = c_CW'(KERNEL_SIZE-1);
   localparam logic [c_CW-1:0] c_IC_LAST = c_CW'(IN_CHANNELS-1);
   localparam logic [c_CW-1:0] c_OC_LAST = c_CW'(OUT_CHANNELS-1);
   localparam logic [c_CW-1:0] c_OH_LAST = c_CW'(OUT_HEIGHT-1);
   localparam logic [c_CW-1:0] c_OW_LAST = c_CW'(OUT_WIDTH-1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_MAC   = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          r_state, w_state;
   logic [c_CW-1:0] r_oc, r_oh, r_ow, r_ic, r_kh, r_kw;
   logic [c_CW-1:0] w_oc, w_oh, w_ow, w_ic, w_kh, w_kw;
   logic            w_held;

   logic signed [31:0]    w_ih, w_iw;
   logic                  w_in_range;
   logic [ADDR_WIDTH-1:0] w_in_lin, w_w_lin, w_out_lin;

   logic                  r_busy, r_done, r_acc_init, r_mac_en, r_in_valid, r_out_we;
   logic [ADDR_WIDTH-1:0] r_in_addr, r_w_addr, r_bias_addr, r_out_addr;

   // Next-state and counter advance; a held cycle keeps everything frozen.
   always_comb begin
      w_state = r_state;
      w_oc    = r_oc;
      w_oh    = r_oh;
      w_ow    = r_ow;
      w_ic    = r_ic;
      w_kh    = r_kh;
      w_kw    = r_kw;
      w_held  = hold && ((r_state == S_INIT) || (r_state == S_MAC) || (r_state == S_WRITE));
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state = S_INIT;
               w_oc = '0; w_oh = '0; w_ow = '0;
               w_ic = '0; w_kh = '0; w_kw = '0;
            end
         end
         S_INIT: begin
            if (!hold) begin
               w_state = S_MAC;
               w_ic = '0; w_kh = '0; w_kw = '0;
            end
         end
         S_MAC: begin
            if (!hold) begin
               if (r_kw != c_K_LAST) begin
                  w_kw = r_kw + c_ONE;
               end else begin
                  w_kw = '0;
                  if (r_kh != c_K_LAST) begin
                     w_kh = r_kh + c_ONE;
                  end else begin
                     w_kh = '0;
                     if (r_ic != c_IC_LAST) begin
                        w_ic = r_ic + c_ONE;
                     end else begin
                        w_ic    = '0;
                        w_state = S_WRITE;
                     end
                  end
               end
            end
         end
         S_WRITE: begin
            if (!hold) begin
               w_state = S_INIT;
               if (r_ow != c_OW_LAST) begin
                  w_ow = r_ow + c_ONE;
               end else begin
                  w_ow = '0;
                  if (r_oh != c_OH_LAST) begin
                     w_oh = r_oh + c_ONE;
                  end else begin
                     w_oh = '0;
                     if (r_oc != c_OC_LAST) begin
                        w_oc = r_oc + c_ONE;
                     end else begin
                        w_oc    = '0;
                        w_state = S_DONE;
                     end
                  end
               end
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
            w_oc = '0; w_oh = '0; w_ow = '0;
            w_ic = '0; w_kh = '0; w_kw = '0;
         end
         default: w_state = S_IDLE;
      endcase
   end

   // Addresses are decoded from the next-cycle counters so outputs can be registered.
   always_comb begin
      w_ih       = int'(w_oh)*STRIDE + int'(w_kh) - PADDING;
      w_iw       = int'(w_ow)*STRIDE + int'(w_kw) - PADDING;
      w_in_range = (w_ih >= 0) && (w_ih < IN_HEIGHT) && (w_iw >= 0) && (w_iw < IN_WIDTH);
      w_in_lin   = ADDR_WIDTH'(int'(w_ic)*IN_HEIGHT*IN_WIDTH + w_ih*IN_WIDTH + w_iw);
      w_w_lin    = ADDR_WIDTH'(int'(w_oc)*TAPS + int'(w_ic)*KERNEL_SIZE*KERNEL_SIZE
                               + int'(w_kh)*KERNEL_SIZE + int'(w_kw));
      w_out_lin  = ADDR_WIDTH'(int'(w_oc)*OUT_HEIGHT*OUT_WIDTH + int'(w_oh)*OUT_WIDTH + int'(w_ow));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_oc        <= '0;
         r_oh        <= '0;
         r_ow        <= '0;
         r_ic        <= '0;
         r_kh        <= '0;
         r_kw        <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_acc_init  <= 1'b0;
         r_mac_en    <= 1'b0;
         r_in_valid  <= 1'b0;
         r_out_we    <= 1'b0;
         r_in_addr   <= '0;
         r_w_addr    <= '0;
         r_bias_addr <= '0;
         r_out_addr  <= '0;
      end else begin
         r_state     <= w_state;
         r_oc        <= w_oc;
         r_oh        <= w_oh;
         r_ow        <= w_ow;
         r_ic        <= w_ic;
         r_kh        <= w_kh;
         r_kw        <= w_kw;
         r_busy      <= (w_state == S_INIT) || (w_state == S_MAC) || (w_state == S_WRITE);
         r_done      <= (w_state == S_DONE);
         r_acc_init  <= (w_state == S_INIT) && !w_held;
         r_mac_en    <= (w_state == S_MAC) && !w_held;
         r_out_we    <= (w_state == S_WRITE) && !w_held;
         r_in_valid  <= (w_state == S_MAC) && w_in_range;
         r_in_addr   <= ((w_state == S_MAC) && w_in_range) ? w_in_lin : '0;
         r_w_addr    <= (w_state == S_MAC) ? w_w_lin : '0;
         r_bias_addr <= (w_state == S_INIT) ? ADDR_WIDTH'(w_oc) : '0;
         r_out_addr  <= (w_state == S_WRITE) ? w_out_lin : '0;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign acc_init  = r_acc_init;
   assign mac_en    = r_mac_en;
   assign in_valid  = r_in_valid;
   assign in_addr   = r_in_addr;
   assign w_addr    = r_w_addr;
   assign bias_addr = r_bias_addr;
   assign out_we    = r_out_we;
   assign out_addr  = r_out_addr;

`ifdef CONV2D_SEQUENCER_PERF_EN
   logic [31:0] r_perf;

   // Counts every cycle spent in INIT/MAC/WRITE, held ones included.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_perf <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_perf <= '0;
      end else if ((r_state == S_INIT) || (r_state == S_MAC) || (r_state == S_WRITE)) begin
         r_perf <= r_perf + 32'd1;
      end
   end

   assign perf_cycles = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv2d_sequencer.sv
`default_nettype none
// Bench for conv2d_sequencer: scoreboard on acc_init/mac_en/out_we traffic plus
// per-scenario cycle-timing checks; DUT b runs the PADDING=1/STRIDE=1 configuration.
module tb_conv2d_sequencer;
   localparam int AW = 16;
   localparam int IC = 2, OC = 1, H = 4, W = 4, K = 2, S = 2, P = 0;
   localparam int OH = (H + 2*P - K)/S + 1;
   localparam int OW = (W + 2*P - K)/S + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int P1_IN[8] = '{2, 3, 6, 7, 18, 19, 22, 23};

   logic          a_rst, a_start, a_hold, b_rst, b_start, b_hold;
   logic          a_busy, a_done, a_acc_init, a_mac_en, a_in_valid, a_out_we;
   logic          b_busy, b_done, b_acc_init, b_mac_en, b_in_valid, b_out_we;
   logic [AW-1:0] a_in_addr, a_w_addr, a_bias_addr, a_out_addr;
   logic [AW-1:0] b_in_addr, b_w_addr, b_bias_addr, b_out_addr;
`ifdef CONV2D_SEQUENCER_PERF_EN
   logic [31:0]   a_perf, b_perf;
`endif

   wire [4*AW+5:0] a_all = {a_busy, a_done, a_acc_init, a_mac_en, a_in_valid, a_out_we,
                            a_in_addr, a_w_addr, a_bias_addr, a_out_addr};
   wire [4*AW+5:0] b_all = {b_busy, b_done, b_acc_init, b_mac_en, b_in_valid, b_out_we,
                            b_in_addr, b_w_addr, b_bias_addr, b_out_addr};

   conv2d_sequencer #(.ADDR_WIDTH(AW)) u_a (
      .clk(clk), .rst(a_rst), .start(a_start), .hold(a_hold),
      .busy(a_busy), .done(a_done), .acc_init(a_acc_init), .mac_en(a_mac_en),
      .in_valid(a_in_valid), .in_addr(a_in_addr), .w_addr(a_w_addr),
      .bias_addr(a_bias_addr), .out_we(a_out_we), .out_addr(a_out_addr)
`ifdef CONV2D_SEQUENCER_PERF_EN
      , .perf_cycles(a_perf)
`endif
   );

   conv2d_sequencer #(.STRIDE(1), .PADDING(1), .ADDR_WIDTH(AW)) u_b (
      .clk(clk), .rst(b_rst), .start(b_start), .hold(b_hold),
      .busy(b_busy), .done(b_done), .acc_init(b_acc_init), .mac_en(b_mac_en),
      .in_valid(b_in_valid), .in_addr(b_in_addr), .w_addr(b_w_addr),
      .bias_addr(b_bias_addr), .out_we(b_out_we), .out_addr(b_out_addr)
`ifdef CONV2D_SEQUENCER_PERF_EN
      , .perf_cycles(b_perf)
`endif
   );

   // Scoreboard queues for DUT a
   logic [AW-1:0] q_bias[$];
   logic [AW-1:0] q_out[$];
   logic [2*AW:0] q_mac[$];
   logic [AW:0]   q_pad[$];
   bit            mon_en = 1'b0;
   logic [AW-1:0] m_eb, m_eo;
   logic [2*AW:0] m_em;

   task automatic model_pass();
      int ih, iw;
      for (int oc = 0; oc < OC; oc++)
         for (int oh = 0; oh < OH; oh++)
            for (int ow = 0; ow < OW; ow++) begin
               q_bias.push_back(AW'(oc));
               for (int ic = 0; ic < IC; ic++)
                  for (int kh = 0; kh < K; kh++)
                     for (int kw = 0; kw < K; kw++) begin
                        ih = oh*S + kh - P;
                        iw = ow*S + kw - P;
                        if (ih >= 0 && ih < H && iw >= 0 && iw < W)
                           q_mac.push_back({1'b1, AW'(ic*H*W + ih*W + iw), AW'(oc*IC*K*K + ic*K*K + kh*K + kw)});
                        else
                           q_mac.push_back({1'b0, AW'(0), AW'(oc*IC*K*K + ic*K*K + kh*K + kw)});
                     end
               q_out.push_back(AW'(oc*OH*OW + oh*OW + ow));
            end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (a_acc_init) begin
            checks++;
            if (q_bias.size() == 0) begin
               errors++;
               $display("FAIL sb_bias: unexpected acc_init, bias_addr=%0d", a_bias_addr);
            end else begin
               m_eb = q_bias.pop_front();
               if (a_bias_addr !== m_eb) begin
                  errors++;
                  $display("FAIL sb_bias: got %0d expected %0d", a_bias_addr, m_eb);
               end
            end
         end
         if (a_mac_en) begin
            checks++;
            if (q_mac.size() == 0) begin
               errors++;
               $display("FAIL sb_mac: unexpected mac_en, in_addr=%0d w_addr=%0d", a_in_addr, a_w_addr);
            end else begin
               m_em = q_mac.pop_front();
               if ({a_in_valid, a_in_addr, a_w_addr} !== m_em) begin
                  errors++;
                  $display("FAIL sb_mac: got v=%b in=%0d w=%0d expected v=%b in=%0d w=%0d",
                           a_in_valid, a_in_addr, a_w_addr, m_em[2*AW], m_em[2*AW-1:AW], m_em[AW-1:0]);
               end
            end
         end
         if (a_out_we) begin
            checks++;
            if (q_out.size() == 0) begin
               errors++;
               $display("FAIL sb_out: unexpected out_we, out_addr=%0d", a_out_addr);
            end else begin
               m_eo = q_out.pop_front();
               if (a_out_addr !== m_eo) begin
                  errors++;
                  $display("FAIL sb_out: got %0d expected %0d", a_out_addr, m_eo);
               end
            end
         end
      end
   end

   task automatic test_reset();
      a_rst = 1'b0; a_start = 1'b0; a_hold = 1'b0;
      b_rst = 1'b0; b_start = 1'b0; b_hold = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (a_all !== '0 || b_all !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got a=%h b=%h expected 0", a_all, b_all);
      end
      a_rst = 1'b1; b_rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (a_all !== '0) begin
            errors++;
            $display("FAIL idle_no_start cyc %0d: got %h expected 0", c, a_all);
         end
      end
   endtask

   task automatic test_pass();
      int ph, busy_n;
      logic [4:0] e_vec, got;
      model_pass();
      mon_en = 1'b1;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      busy_n = 0;
      for (int c = 1; c <= 42; c++) begin
         ph = (c - 1) % 10;
         e_vec = {(c <= 40), (c == 41), (c <= 40) && (ph == 0),
                  (c <= 40) && (ph >= 1) && (ph <= 8), (c <= 40) && (ph == 9)};
         got = {a_busy, a_done, a_acc_init, a_mac_en, a_out_we};
         checks++;
         if (got !== e_vec) begin
            errors++;
            $display("FAIL pass_strobes cyc %0d: got %b expected %b", c, got, e_vec);
         end
         if (a_busy) busy_n++;
         if (c == 10) begin
            checks++;
            if (a_out_addr !== AW'(0)) begin
               errors++;
               $display("FAIL first_out_addr: got %0d expected 0", a_out_addr);
            end
         end
         if (c >= 12 && c <= 19) begin
            checks++;
            if (a_in_addr !== AW'(P1_IN[c-12]) || a_w_addr !== AW'(c-12)) begin
               errors++;
               $display("FAIL pos1_addr tap %0d: got in=%0d w=%0d expected in=%0d w=%0d",
                        c-12, a_in_addr, a_w_addr, P1_IN[c-12], c-12);
            end
         end
         if (c == 41) a_start = 1'b1;
         if (c == 42) a_start = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (a_all !== '0) begin
         errors++;
         $display("FAIL start_in_done_ignored: got %h expected 0", a_all);
      end
      checks++;
      if (busy_n != 40) begin
         errors++;
         $display("FAIL pass_busy_cycles: got %0d expected 40", busy_n);
      end
      checks++;
      if (q_bias.size() + q_mac.size() + q_out.size() != 0) begin
         errors++;
         $display("FAIL pass_sb_drain: got %0d left expected 0", q_bias.size() + q_mac.size() + q_out.size());
      end
`ifdef CONV2D_SEQUENCER_PERF_EN
      checks++;
      if (a_perf !== 32'd40) begin
         errors++;
         $display("FAIL perf_pass: got %0d expected 40", a_perf);
      end
`endif
      mon_en = 1'b0;
   endtask

   task automatic test_hold();
      int ph, cp, busy_n;
      bit held, act;
      logic [4:0] e_vec, got;
      model_pass();
      mon_en = 1'b1;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      busy_n = 0;
      for (int c = 1; c <= 45; c++) begin
         held = (c >= 6 && c <= 8);
         cp = (c > 8) ? c - 3 : c;
         ph = (cp - 1) % 10;
         act = (cp <= 40);
         e_vec = {act, (cp == 41), act && !held && (ph == 0),
                  act && !held && (ph >= 1) && (ph <= 8), act && !held && (ph == 9)};
         got = {a_busy, a_done, a_acc_init, a_mac_en, a_out_we};
         checks++;
         if (got !== e_vec) begin
            errors++;
            $display("FAIL hold_strobes cyc %0d: got %b expected %b", c, got, e_vec);
         end
         if (held) begin
            checks++;
            if ({a_in_valid, a_in_addr, a_w_addr} !== {1'b1, AW'(5), AW'(3)}) begin
               errors++;
               $display("FAIL hold_addr_frozen cyc %0d: got v=%b in=%0d w=%0d expected v=1 in=5 w=3",
                        c, a_in_valid, a_in_addr, a_w_addr);
            end
         end
         if (a_busy) busy_n++;
         if (c == 5) a_hold = 1'b1;
         if (c == 8) a_hold = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (busy_n != 43) begin
         errors++;
         $display("FAIL hold_busy_cycles: got %0d expected 43", busy_n);
      end
      checks++;
      if (q_bias.size() + q_mac.size() + q_out.size() != 0) begin
         errors++;
         $display("FAIL hold_sb_drain: got %0d left expected 0", q_bias.size() + q_mac.size() + q_out.size());
      end
`ifdef CONV2D_SEQUENCER_PERF_EN
      checks++;
      if (a_perf !== 32'd43) begin
         errors++;
         $display("FAIL perf_hold: got %0d expected 43", a_perf);
      end
`endif
      mon_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (!a_mac_en) begin
         errors++;
         $display("FAIL midreset_precond: got mac_en=%b expected 1", a_mac_en);
      end
      a_rst = 1'b0;
      @(negedge clk);
      checks++;
      if (a_all !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got %h expected 0", a_all);
      end
      a_rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (a_all !== '0) begin
            errors++;
            $display("FAIL midreset_idle cyc %0d: got %h expected 0", c, a_all);
         end
      end
   endtask

   task automatic test_padding();
      logic [AW:0] e_pad;
      int done_at;
      for (int ic = 0; ic < IC; ic++)
         for (int kh = 0; kh < K; kh++)
            for (int kw = 0; kw < K; kw++)
               q_pad.push_back((kh == 1 && kw == 1) ? {1'b1, AW'(ic*H*W)} : {1'b0, AW'(0)});
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      done_at = 0;
      for (int c = 1; c <= 400; c++) begin
         if (b_mac_en && q_pad.size() != 0) begin
            e_pad = q_pad.pop_front();
            checks++;
            if ({b_in_valid, b_in_addr} !== e_pad) begin
               errors++;
               $display("FAIL pad_in_valid cyc %0d: got v=%b in=%0d expected v=%b in=%0d",
                        c, b_in_valid, b_in_addr, e_pad[AW], e_pad[AW-1:0]);
            end
         end
         if (b_done) begin
            done_at = c;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (done_at != 251 || q_pad.size() != 0) begin
         errors++;
         $display("FAIL pad_pass_done: got done at %0d (%0d taps unseen) expected 251 (0)", done_at, q_pad.size());
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_hold();
      test_reset_mid();
      test_padding();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
